// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants.
// Used by uart_rx and by the planned uart_tx.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam logic [3:0] MID_TICK = 4'd7;
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick divider: one-cycle tick every DIV clocks, phase reset by clr_i.
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  assign tick_o = (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, byte output plus valid strobe.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err port.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       en,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);

  logic        rx_meta_q, rx_s_q, rx_prev_q;
  logic [1:0]  flush_q;
  logic        armed_q;
  uart_state_e state_q;
  logic [3:0]  tick_cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        en_q, frame_err_q, busy_q;
  logic        tick, start_edge, par_ok;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_err_q;
  assign par_ok = ~par_bad_q;
  assign parity_err = par_err_q;
`else
  assign par_ok = 1'b1;
`endif

  // armed_q ignores the reset value of the synchroniser, so a frame
  // already on the wire at reset release cannot fake a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      flush_q   <= 2'b00;
      armed_q   <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      flush_q   <= {flush_q[0], 1'b1};
      armed_q   <= armed_q | (flush_q[1] & rx_s_q);
    end
  end

  assign start_edge = (state_q == IDLE) & armed_q
                    & rx_prev_q & ~rx_s_q;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (start_edge),
    .tick_o (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tick_cnt_q  <= 4'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      en_q        <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      en_q        <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
      if (tick) tick_cnt_q <= tick_cnt_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          if (start_edge) begin
            tick_cnt_q <= 4'd0;
            bit_idx_q  <= 3'd0;
            busy_q     <= 1'b1;
            state_q    <= START;
          end
        end
        START: begin
          if (tick && tick_cnt_q == MID_TICK) begin
            if (!rx_s_q) begin
              tick_cnt_q <= 4'd0;
              bit_idx_q  <= 3'd0;
              state_q    <= DATA;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick && tick_cnt_q == LAST_TICK) begin
            shift_q <= {rx_s_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick && tick_cnt_q == LAST_TICK) begin
            par_bad_q <= ^{shift_q, rx_s_q};
            state_q   <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick && tick_cnt_q == LAST_TICK) begin
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_bad_q;
`endif
            if (rx_s_q) begin
              if (par_ok) begin
                data_q <= shift_q;
                en_q   <= 1'b1;
              end
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (rx_s_q) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data      = data_q;
  assign en        = en_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at DIV = 10 (160 clk per bit).
// Define UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT = 160;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 1523 + BIT;
`else
  localparam int LAT = 1523;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       en, frame_err, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_FREQ (1_600_000),
    .BAUD     (10_000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .en         (en),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_en = 0, n_fe = 0, n_pe = 0;
  int n_wide = 0, n_both = 0;
  int en_cyc = 0, st_cyc = 0;
  logic [7:0] cap[$];
  logic en_d = 1'b0, fe_d = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (en) begin
      n_en++;
      cap.push_back(data);
      en_cyc = cyc;
    end
    if (frame_err) n_fe++;
    if ((en && en_d) || (frame_err && fe_d)) n_wide++;
    if (en && frame_err) n_both++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) n_pe++;
`endif
    en_d = en;
    fe_d = frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bitv(input logic v);
    @(negedge clk);
    rx = v;
    repeat (BIT - 1) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stopv);
    @(negedge clk);
    rx = 1'b0;
    st_cyc = cyc;
    repeat (BIT - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) bitv(b[i]);
`ifdef UART_RX_PARITY_EN
    bitv(^b);
`endif
    bitv(stopv);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_badpar(input logic [7:0] b);
    bitv(1'b0);
    for (int i = 0; i < 8; i++) bitv(b[i]);
    bitv(~(^b));
    bitv(1'b1);
  endtask
`endif

  initial begin
    int e0, f0, lat;
    logic [7:0] c3;
    c3 = 8'hC3;

    repeat (5) @(negedge clk);
    chk("rst_data", data, 8'h00);
    chk("rst_en", en, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    e0 = n_en;
    send(8'h41, 1'b1);
    repeat (20) @(negedge clk);
    chk("41_en_cnt", n_en, e0 + 1);
    chk("41_data", data, 8'h41);
    chk("41_ferr_cnt", n_fe, 0);
    lat = en_cyc - st_cyc;
    chk("41_latency_ok", (lat >= LAT - 2 && lat <= LAT + 2), 1'b1);
    if (lat < LAT - 2 || lat > LAT + 2)
      $display("latency observed %0d expected %0d", lat, LAT);

    send(8'h55, 1'b1);
    send(8'hA3, 1'b1);
    repeat (20) @(negedge clk);
    chk("b2b_en_cnt", n_en, e0 + 3);
    chk("b2b_first", cap[1], 8'h55);
    chk("b2b_second", cap[2], 8'hA3);
    chk("b2b_data", data, 8'hA3);
    chk("b2b_ferr_cnt", n_fe, 0);

    @(negedge clk);
    rx = 1'b0;
    repeat (30) @(negedge clk);
    chk("glitch_busy_hi", busy, 1'b1);
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_en_cnt", n_en, e0 + 3);
    chk("glitch_ferr_cnt", n_fe, 0);
    chk("glitch_busy_lo", busy, 1'b0);
    chk("glitch_state", 32'(dut.state_q), 32'(IDLE));

    f0 = n_fe;
    send(8'h7E, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    chk("ferr_cnt", n_fe, f0 + 1);
    chk("ferr_no_en", n_en, e0 + 3);
    chk("ferr_data_kept", data, 8'hA3);
    chk("ferr_busy_low_line", busy, 1'b1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    chk("ferr_busy_released", busy, 1'b0);

    bitv(1'b0);
    for (int i = 0; i < 4; i++) bitv(c3[i]);
    @(negedge clk);
    rx = c3[4];
    repeat (80) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (BIT - 84) @(negedge clk);
    for (int i = 5; i < 8; i++) bitv(c3[i]);
`ifdef UART_RX_PARITY_EN
    bitv(^c3);
`endif
    bitv(1'b1);
    repeat (40) @(negedge clk);
    chk("mid_rst_no_en", n_en, e0 + 3);
    chk("mid_rst_no_ferr", n_fe, f0 + 1);
    chk("mid_rst_idle", busy, 1'b0);
    send(8'h12, 1'b1);
    repeat (20) @(negedge clk);
    chk("after_rst_en_cnt", n_en, e0 + 4);
    chk("after_rst_data", data, 8'h12);

`ifdef UART_RX_PARITY_EN
    send(8'h03, 1'b1);
    repeat (20) @(negedge clk);
    chk("par_ok_en_cnt", n_en, e0 + 5);
    chk("par_ok_data", data, 8'h03);
    chk("par_ok_no_perr", n_pe, 0);
    send_badpar(8'h03);
    repeat (20) @(negedge clk);
    chk("par_bad_perr", n_pe, 1);
    chk("par_bad_no_en", n_en, e0 + 5);
    chk("par_bad_ferr", n_fe, f0 + 1);
`endif

    chk("pulse_width_1clk", n_wide, 0);
    chk("en_ferr_exclusive", n_both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
